// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: cache-side request/response ports and RAM port bundled for the arbiter
interface memory_arbiter_if #(parameter int NCPU = 2);
  logic [NCPU-1:0] iREN, iwait, dREN, dWEN, cctrans, dwait;
  logic [NCPU-1:0][31:0] iaddr, iload, daddr, dstore, dload;
  logic ramREN, ramWEN, timeout_err;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0] ramstate;
  modport slave (
    input iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, timeout_err
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ramload, ramstate,
    input iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, timeout_err
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin icache/dcache arbiter onto one RAM port with dcache block lock and timeout
module memory_arbiter #(
  parameter int NCPU = 2,
  parameter int TIMEOUT = 255
) (
  input logic CLK,
  input logic nRST,
  memory_arbiter_if.slave bus
);
  localparam int IW = NCPU > 1 ? $clog2(NCPU) : 1;
  typedef enum logic {ARB, XFER} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] gidx_q, gidx_d, lock_q, lock_d, rr_q, rr_d, didx, iidx, pj;
  logic gd_q, gd_d, lockv_q, lockv_d, terr_q, terr_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [NCPU-1:0] dreq;
  logic req, wr, acc, lock_hit, dfound, ifound;
  assign dreq = bus.dREN | bus.dWEN;
  assign acc = bus.ramstate == 2'd2;
  assign bus.timeout_err = terr_q;
  // Scan downwards so the core nearest rr wins the last assignment
  always_comb begin
    didx = '0;
    iidx = '0;
    dfound = 1'b0;
    ifound = 1'b0;
    pj = '0;
    for (int k = NCPU - 1; k >= 0; k--) begin
      pj = IW'((int'(rr_q) + k) % NCPU);
      if (dreq[pj]) begin
        dfound = 1'b1;
        didx = pj;
      end
      if (bus.iREN[pj]) begin
        ifound = 1'b1;
        iidx = pj;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    gidx_d = gidx_q;
    gd_d = gd_q;
    lock_d = lock_q;
    lockv_d = lockv_q;
    rr_d = rr_q;
    tcnt_d = tcnt_q;
    terr_d = terr_q;
    bus.iwait = '1;
    bus.dwait = '1;
    bus.iload = '0;
    bus.dload = '0;
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b0;
    bus.ramaddr = '0;
    bus.ramstore = '0;
    req = gd_q ? dreq[gidx_q] : bus.iREN[gidx_q];
    wr = gd_q && bus.dWEN[gidx_q];
    lock_hit = lockv_q && bus.cctrans[lock_q];
    if (state_q == ARB) begin
      lockv_d = lock_hit;
      tcnt_d = '0;
      state_d = (dfound || ifound) ? XFER : ARB;
      gd_d = (lock_hit && dreq[lock_q]) || dfound;
      gidx_d = (lock_hit && dreq[lock_q]) ? lock_q : dfound ? didx : iidx;
    end else if (!req) begin
      state_d = ARB;
      tcnt_d = '0;
      lockv_d = lock_hit;
    end else begin
      bus.ramWEN = wr;
      bus.ramREN = !wr;
      bus.ramaddr = gd_q ? bus.daddr[gidx_q] : bus.iaddr[gidx_q];
      bus.ramstore = wr ? bus.dstore[gidx_q] : '0;
      if (acc) begin
        if (gd_q) begin
          bus.dwait[gidx_q] = 1'b0;
          bus.dload[gidx_q] = bus.ramload;
        end else begin
          bus.iwait[gidx_q] = 1'b0;
          bus.iload[gidx_q] = bus.ramload;
        end
        state_d = ARB;
        tcnt_d = '0;
        rr_d = gidx_q == IW'(NCPU - 1) ? '0 : gidx_q + 1'b1;
        if (gd_q && bus.cctrans[gidx_q]) begin
          lockv_d = 1'b1;
          lock_d = gidx_q;
        end
      end else begin
        tcnt_d = tcnt_q == 8'(TIMEOUT) ? tcnt_q : tcnt_q + 8'd1;
        terr_d = terr_q || tcnt_d == 8'(TIMEOUT);
      end
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ARB;
      gidx_q <= '0;
      gd_q <= 1'b0;
      lock_q <= '0;
      lockv_q <= 1'b0;
      rr_q <= '0;
      tcnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gidx_q <= gidx_d;
      gd_q <= gd_d;
      lock_q <= lock_d;
      lockv_q <= lockv_d;
      rr_q <= rr_d;
      tcnt_q <= tcnt_d;
      terr_q <= terr_d;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_memory_arbiter;
  logic CLK, nRST;
  int checks = 0, passed = 0;
  memory_arbiter_if #(.NCPU(2)) bus();
  memory_arbiter #(.NCPU(2), .TIMEOUT(255)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic at_neg();
    @(negedge CLK);
  endtask
  task automatic idle();
    bus.iREN = '0;
    bus.dREN = '0;
    bus.dWEN = '0;
    bus.cctrans = '0;
    bus.iaddr = '0;
    bus.daddr = '0;
    bus.dstore = '0;
    bus.ramload = '0;
    bus.ramstate = 2'd0;
  endtask
  task automatic do_reset();
    nRST = 1'b0;
    step();
    nRST = 1'b1;
  endtask
  // Transaction-level model: who owns the RAM, lock owner, fairness pointer, stall count
  bit m_busy, m_gd, m_gi, m_lockv, m_lock, m_rr, m_err, found, req;
  int m_cnt;
  logic [1:0] e_iw, e_dw;
  logic [1:0][31:0] e_il, e_dl;
  logic e_ren, e_wen, e_err;
  logic [31:0] e_addr, e_store;
  always @(negedge CLK) begin
    e_iw = '1;
    e_dw = '1;
    e_il = '0;
    e_dl = '0;
    e_ren = 1'b0;
    e_wen = 1'b0;
    e_addr = '0;
    e_store = '0;
    if (!nRST) begin
      m_busy = 0; m_gd = 0; m_gi = 0; m_lockv = 0; m_lock = 0; m_rr = 0; m_err = 0; m_cnt = 0;
    end
    e_err = m_err;
    if (nRST && m_busy) begin
      req = m_gd ? (bus.dREN[m_gi] | bus.dWEN[m_gi]) : bus.iREN[m_gi];
      if (!req) begin
        m_busy = 0;
        m_cnt = 0;
        if (m_lockv && !bus.cctrans[m_lock]) m_lockv = 0;
      end else begin
        if (m_gd && bus.dWEN[m_gi]) begin
          e_wen = 1'b1;
          e_addr = bus.daddr[m_gi];
          e_store = bus.dstore[m_gi];
        end else begin
          e_ren = 1'b1;
          e_addr = m_gd ? bus.daddr[m_gi] : bus.iaddr[m_gi];
        end
        if (bus.ramstate == 2'd2) begin
          if (m_gd) begin
            e_dw[m_gi] = 1'b0;
            e_dl[m_gi] = bus.ramload;
          end else begin
            e_iw[m_gi] = 1'b0;
            e_il[m_gi] = bus.ramload;
          end
          m_rr = ~m_gi;
          if (m_gd && bus.cctrans[m_gi]) begin
            m_lockv = 1;
            m_lock = m_gi;
          end
          m_busy = 0;
          m_cnt = 0;
        end else begin
          if (m_cnt < 255) m_cnt++;
          if (m_cnt == 255) m_err = 1;
        end
      end
    end else if (nRST) begin
      if (m_lockv && !bus.cctrans[m_lock]) m_lockv = 0;
      found = 0;
      if (m_lockv && (bus.dREN[m_lock] | bus.dWEN[m_lock])) begin
        found = 1; m_gd = 1; m_gi = m_lock;
      end
      for (int k = 0; k < 2; k++)
        if (!found && (bus.dREN[m_rr ^ k[0]] | bus.dWEN[m_rr ^ k[0]])) begin
          found = 1; m_gd = 1; m_gi = m_rr ^ k[0];
        end
      for (int k = 0; k < 2; k++)
        if (!found && bus.iREN[m_rr ^ k[0]]) begin
          found = 1; m_gd = 0; m_gi = m_rr ^ k[0];
        end
      m_busy = found;
      m_cnt = 0;
    end
    chk("iwait", bus.iwait, e_iw);
    chk("dwait", bus.dwait, e_dw);
    chk("iload", bus.iload, e_il);
    chk("dload", bus.dload, e_dl);
    chk("ramstrobe", {bus.ramREN, bus.ramWEN}, {e_ren, e_wen});
    chk("ramaddr", bus.ramaddr, e_addr);
    chk("ramstore", bus.ramstore, e_store);
    chk("timeout_err", bus.timeout_err, e_err);
  end
  logic [1:0] exp4 [8] = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01};
  initial begin
    nRST = 1'b0;
    idle();
    step();
    at_neg();
    chk("rst_waits", {bus.iwait, bus.dwait}, 4'hF);
    chk("rst_ram", {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore}, '0);
    step();
    nRST = 1'b1;
    // single dcache read, ACCESS two cycles after the request
    step();
    bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h100; bus.ramstate = 2'd1;
    step();
    at_neg();
    chk("t1_ram", {bus.ramREN, bus.ramaddr}, {1'b1, 32'h100});
    chk("t1_wait_hi", bus.dwait, 2'b11);
    step();
    bus.ramstate = 2'd2; bus.ramload = 32'hCAFE;
    at_neg();
    chk("t1_wait_lo", bus.dwait, 2'b10);
    chk("t1_dload", bus.dload[0], 32'hCAFE);
    step();
    idle();
    at_neg();
    chk("t1_done", bus.dwait, 2'b11);
    // dcache beats icache
    step();
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h0;
    bus.dWEN[1] = 1'b1; bus.daddr[1] = 32'h200; bus.dstore[1] = 32'h55;
    bus.ramstate = 2'd2; bus.ramload = 32'h1234;
    step();
    at_neg();
    chk("t2_dwrite", {bus.ramWEN, bus.ramaddr, bus.ramstore}, {1'b1, 32'h200, 32'h55});
    chk("t2_dwait", bus.dwait, 2'b01);
    step();
    bus.dWEN[1] = 1'b0;
    step();
    at_neg();
    chk("t2_iread", {bus.ramREN, bus.ramaddr}, {1'b1, 32'h0});
    chk("t2_iwait", {bus.iwait, bus.iload[0]}, {2'b10, 32'h1234});
    step();
    idle();
    // round-robin fairness among icaches
    do_reset();
    bus.iREN = 2'b11; bus.iaddr[0] = 32'h10; bus.iaddr[1] = 32'h20; bus.ramstate = 2'd2;
    for (int i = 0; i < 8; i++) begin
      at_neg();
      chk($sformatf("t4_iwait%0d", i), bus.iwait, exp4[i]);
      step();
    end
    idle();
    // core1 locked block transfer holds off core0
    step();
    bus.dWEN[1] = 1'b1; bus.cctrans[1] = 1'b1; bus.daddr[1] = 32'h300; bus.dstore[1] = 32'hA;
    bus.ramstate = 2'd2;
    step();
    at_neg();
    chk("t3_w0", {bus.dwait, bus.ramaddr}, {2'b01, 32'h300});
    step();
    bus.daddr[1] = 32'h304; bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h400;
    step();
    at_neg();
    chk("t3_w1", {bus.dwait, bus.ramaddr}, {2'b01, 32'h304});
    step();
    bus.dWEN[1] = 1'b0; bus.cctrans[1] = 1'b0;
    step();
    at_neg();
    chk("t3_core0", {bus.dwait, bus.ramREN, bus.ramaddr}, {2'b10, 1'b1, 32'h400});
    step();
    idle();
    // RAM stalls past the timeout, then completes
    step();
    bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h600; bus.ramstate = 2'd1;
    for (int i = 1; i <= 300; i++) begin
      step();
      at_neg();
      if (i == 255) chk("t5_err_before", bus.timeout_err, 1'b0);
      if (i == 256 || i == 300) chk($sformatf("t5_err%0d", i), {bus.timeout_err, bus.dwait}, {1'b1, 2'b11});
    end
    step();
    bus.ramstate = 2'd2; bus.ramload = 32'h77;
    at_neg();
    chk("t5_late", {bus.dwait, bus.dload[0]}, {2'b10, 32'h77});
    step();
    idle();
    // withdrawal, then reset in the middle of a transfer
    step();
    bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h500; bus.ramstate = 2'd1;
    step();
    at_neg();
    chk("t6_xfer", {bus.ramREN, bus.timeout_err}, 2'b11);
    step();
    bus.dREN[0] = 1'b0;
    at_neg();
    chk("t6_withdraw", {bus.dwait, bus.ramREN}, {2'b11, 1'b0});
    step();
    bus.dREN[0] = 1'b1;
    step();
    nRST = 1'b0;
    at_neg();
    chk("t6_reset", {bus.iwait, bus.dwait, bus.ramREN, bus.timeout_err}, {4'hF, 2'b00});
    step();
    nRST = 1'b1;
    idle();
    // randomized traffic
    repeat (3000) begin
      step();
      nRST = $urandom_range(499) != 0;
      for (int c = 0; c < 2; c++) begin
        if (!bus.iREN[c]) begin
          if ($urandom_range(3) == 0) begin bus.iREN[c] = 1'b1; bus.iaddr[c] = $urandom; end
        end else if ($urandom_range(15) == 0) bus.iREN[c] = 1'b0;
        if (!(bus.dREN[c] | bus.dWEN[c])) begin
          if ($urandom_range(2) == 0) begin
            bus.dREN[c] = 1'($urandom); bus.dWEN[c] = 1'($urandom);
            bus.daddr[c] = $urandom; bus.dstore[c] = $urandom;
          end
        end else if ($urandom_range(15) == 0) begin
          bus.dREN[c] = 1'b0; bus.dWEN[c] = 1'b0;
        end
        if ($urandom_range(7) == 0) bus.cctrans[c] = ~bus.cctrans[c];
      end
      bus.ramstate = $urandom_range(2) == 0 ? 2'd2 : 2'($urandom_range(3));
      bus.ramload = $urandom;
    end
    nRST = 1'b1;
    idle();
    repeat (3) step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
